// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
// Optional performance counters are enabled with the MEM_ARB_PERF_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  localparam int REQ_IF   = 0;
  localparam int REQ_D    = 1;
  localparam int STARVE_W = 4;

  // Saturating increment so a long data burst cannot wrap the starvation count.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] v);
    return (&v) ? v : v + {{(STARVE_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Free-running conflict / memory-wait counters for the arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        conflict,
  input  logic        stall,
  output logic [31:0] perf_conflict,
  output logic [31:0] perf_wait
);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_wait     <= '0;
    end else begin
      if (conflict) perf_conflict <= perf_conflict + 32'd1;
      if (stall)    perf_wait     <= perf_wait + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins unless fetch has been starved MAX_WAIT times; MEM_ARB_PERF_EN adds perf counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_done,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_W-1:0]     mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict,
  output logic [31:0]           perf_wait
`endif
);

  localparam logic [STARVE_W-1:0] MAX_WAIT_C = MAX_WAIT[STARVE_W-1:0];

  arb_state_e          state;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_d;
  logic                grant_i;
  logic                busy;

  assign grant_d = d_req && (!if_req || (starve_cnt < MAX_WAIT_C));
  assign grant_i = if_req && !grant_d;
  assign busy    = (state == BUSY_I) || (state == BUSY_D);

  // Completion is combinational on mem_ready; a reset edge suppresses the pulse.
  assign if_done  = !reset && (state == BUSY_I) && mem_ready;
  assign d_done   = !reset && (state == BUSY_D) && mem_ready;
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            mem_wstrb  <= d_wstrb;
            state      <= BUSY_D;
            starve_cnt <= if_req ? starve_inc(starve_cnt) : '0;
          end else if (grant_i) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            state      <= BUSY_I;
            starve_cnt <= '0;
          end else begin
            // Reaching here means no fetch is pending, so starvation history is dropped.
            mem_req    <= 1'b0;
            starve_cnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .clk           (clk),
    .reset         (reset),
    .conflict      ((state == IDLE) && if_req && d_req),
    .stall         (busy && !mem_ready),
    .perf_conflict (perf_conflict),
    .perf_wait     (perf_wait)
  );
`else
  logic unused_busy;
  assign unused_busy = busy;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model answers mem_req, completions are
// matched in order against expected requester IDs and read data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict;
  logic [31:0] perf_wait;
`endif

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_wait(perf_wait)
`endif
  );

  typedef struct {
    int          id;
    logic [31:0] rdata;
    bit          chk;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tb_mem[logic [31:0]];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_wait_cfg = 0;
  int wait_left = 0;
  bit in_txn = 0;
  bit glitch = 0;
  bit auto_drop = 1;
  int req_hi_cnt = 0;
  int last_done_cyc = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic exp_t mk(input int id, input logic [31:0] rd, input bit chk);
    exp_t e;
    e.id = id; e.rdata = rd; e.chk = chk;
    return e;
  endfunction

  // One clock: memory model drives ready/rdata at negedge, then completions are scored.
  task automatic cycle();
    exp_t        e;
    int          id;
    logic [31:0] word;
    logic [31:0] got;
    @(negedge clk);
    cyc++;
    if (mem_req) req_hi_cnt++;
    if (mem_req && !in_txn) begin
      in_txn = 1;
      wait_left = mem_wait_cfg;
    end
    if (in_txn) begin
      if (wait_left == 0) begin
        mem_ready = 1'b1;
        mem_rdata = mem_read(mem_addr);
        if (mem_we) begin
          word = mem_read(mem_addr);
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
          tb_mem[mem_addr] = word;
        end
        in_txn = 0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        wait_left--;
      end
    end else begin
      mem_ready = glitch;
      mem_rdata = 32'hBAD0_BAD0;
    end
    #1;
    if (if_done || d_done) begin
      checks++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: if_done=%0b d_done=%0b, required no completion", if_done, d_done);
      end else begin
        e = exp_q.pop_front();
        id = (if_done && d_done) ? -1 : (d_done ? REQ_D : REQ_IF);
        if (id !== e.id) begin
          errors++;
          $display("FAIL grant_order: requester=%0d, required %0d", id, e.id);
        end
        if (e.chk) begin
          checks++;
          got = d_done ? d_rdata : if_rdata;
          if (got !== e.rdata) begin
            errors++;
            $display("FAIL rdata: got %h, required %h", got, e.rdata);
          end
        end
      end
      if (auto_drop) begin
        if (d_done)  d_req  = 1'b0;
        if (if_done) if_req = 1'b0;
      end
    end
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d completions pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0;
    in_txn = 0; glitch = 0;
    mem_ready = 0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_mem: req=%0b we=%0b addr=%h wdata=%h wstrb=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    checks++;
    if ({if_done, d_done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_done: if_done=%0b d_done=%0b, required 0 0", if_done, d_done);
    end
  endtask

  task automatic test_single_fetch();
    tb_mem[32'h10] = 32'h0050_0093;
    mem_wait_cfg = 2;
    req_hi_cnt = 0;
    exp_q.push_back(mk(REQ_IF, 32'h0050_0093, 1));
    if_addr = 32'h10;
    if_req = 1'b1;
    run_until_empty(20);
    checks++;
    if (req_hi_cnt !== 3) begin
      errors++;
      $display("FAIL fetch_req_cycles: got %0d, required 3", req_hi_cnt);
    end
  endtask

  task automatic test_store();
    int start;
    logic [31:0] exp_load;
    cycle();
    mem_wait_cfg = 0;
    d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    exp_q.push_back(mk(REQ_D, 32'h0, 0));
    start = cyc;
    d_req = 1'b1;
    cycle();
    checks++;
    if ({mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_fields: req=%0b we=%0b wstrb=%b addr=%h wdata=%h, required 1 1 0011 00002000 deadbeef",
               mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata);
    end
    run_until_empty(10);
    checks++;
    if (last_done_cyc - start !== 1) begin
      errors++;
      $display("FAIL store_latency: done %0d cycles after request, required 1", last_done_cyc - start);
    end
    exp_load = ((32'h2000 ^ 32'h5A5A_0000) & 32'hFFFF_0000) | 32'h0000_BEEF;
    d_we = 0; d_wstrb = 4'b0000;
    exp_q.push_back(mk(REQ_D, exp_load, 1));
    d_req = 1'b1;
    run_until_empty(10);
  endtask

  task automatic test_back_to_back();
    int start;
    cycle();
    mem_wait_cfg = 0;
    auto_drop = 0;
    if_addr = 32'h100;
    d_addr = 32'h3000; d_we = 0; d_wstrb = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) exp_q.push_back(mk(REQ_IF, mem_read(32'h100), 1));
      else            exp_q.push_back(mk(REQ_D,  mem_read(32'h3000), 1));
    end
    start = cyc;
    if_req = 1; d_req = 1;
    run_until_empty(60);
    if_req = 0; d_req = 0;
    auto_drop = 1;
    checks++;
    if (last_done_cyc - start !== 19) begin
      errors++;
      $display("FAIL back_to_back_span: last done at +%0d, required +19", last_done_cyc - start);
    end
    cycle();
  endtask

  task automatic test_drop_req();
    mem_wait_cfg = 2;
    if_addr = 32'h20;
    exp_q.push_back(mk(REQ_IF, mem_read(32'h20), 1));
    if_req = 1'b1;
    cycle();
    if_req = 1'b0;
    run_until_empty(10);
    cycle();
  endtask

  task automatic test_reset_mid();
    mem_wait_cfg = 5;
    d_we = 0; d_addr = 32'h3004; d_wstrb = 4'b0000;
    d_req = 1'b1;
    cycle();
    cycle();
    reset = 1'b1;
    d_req = 1'b0;
    cycle();
    checks++;
    if ({mem_req, if_done, d_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_abort: mem_req=%0b if_done=%0b d_done=%0b, required 0 0 0", mem_req, if_done, d_done);
    end
    reset = 1'b0;
    in_txn = 0;
    mem_wait_cfg = 1;
    d_addr = 32'h3008;
    exp_q.push_back(mk(REQ_D, mem_read(32'h3008), 1));
    d_req = 1'b1;
    run_until_empty(10);
    cycle();
  endtask

  task automatic test_idle_glitch();
    cycle();
    glitch = 1;
    cycle();
    checks++;
    if ({mem_ready, if_done, d_done} !== 3'b100) begin
      errors++;
      $display("FAIL idle_glitch_done: ready=%0b if_done=%0b d_done=%0b, required 1 0 0", mem_ready, if_done, d_done);
    end
    glitch = 0;
    cycle();
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_glitch_req: mem_req=%0b, required 0", mem_req);
    end
    mem_wait_cfg = 0;
    if_addr = 32'h44;
    exp_q.push_back(mk(REQ_IF, mem_read(32'h44), 1));
    if_req = 1'b1;
    run_until_empty(10);
    cycle();
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    mem_wait_cfg = 5;
    if_addr = 32'h80;
    exp_q.push_back(mk(REQ_IF, mem_read(32'h80), 1));
    if_req = 1'b1;
    run_until_empty(20);
    mem_wait_cfg = 0;
    auto_drop = 0;
    d_addr = 32'h3010; d_we = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(REQ_D, mem_read(32'h3010), 1));
    if_req = 1; d_req = 1;
    run_until_empty(20);
    if_req = 0; d_req = 0;
    auto_drop = 1;
    cycle();
    checks++;
    if (perf_conflict !== 32'd3) begin
      errors++;
      $display("FAIL perf_conflict: got %0d, required 3", perf_conflict);
    end
    checks++;
    if (perf_wait !== 32'd5) begin
      errors++;
      $display("FAIL perf_wait: got %0d, required 5", perf_wait);
    end
  endtask
`endif

  initial begin
    reset = 1; if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    test_reset();
    test_single_fetch();
    test_store();
    test_back_to_back();
    test_drop_req();
    test_reset_mid();
    test_idle_glitch();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the load/store (MEM) stage of the pipelined CPU.
- Grants one transaction at a time and drives a variable-latency req/ready memory interface.
- Returns per-requester done pulses with read data; the hazard logic uses these to stall IF or MEM.
- Data has priority over fetch, with a bounded fetch-starvation guard.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-strobe width is DATA_W/8.
- MAX_WAIT, 4: consecutive data grants, with fetch pending, after which fetch wins the next arbitration. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle pulse; the fetch completes this cycle.
- if_rdata  out  DATA_W  instruction word; valid only while if_done=1.
- d_req  in  1  load/store request; held with its fields stable until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  byte enables for stores.
- d_done  out  1  one-cycle pulse; the load/store completes this cycle.
- d_rdata  out  DATA_W  load data; valid only while d_done=1.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_wstrb  out  DATA_W/8  memory byte strobes (registered).
- mem_ready  in  1  memory completes the transaction presented this cycle.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.

Behaviour:
- Reset values:
  - state=IDLE; mem_req/mem_we=0; mem_addr/mem_wdata/mem_wstrb=0.
  - starve_cnt=0; if_done/d_done=0.
  - Reset mid-transaction aborts it: no done pulse, mem_req low after the reset edge.
- State IDLE:
  - If d_req and (!if_req or starve_cnt<MAX_WAIT): register the d_* fields onto mem_*, set mem_req=1, go to BUSY_D.
  - Else if if_req: register if_addr, mem_we=0, mem_wstrb=0, mem_wdata=0, mem_req=1, go to BUSY_I.
  - Else stay in IDLE with mem_req=0.
- BUSY_I / BUSY_D:
  - mem_* are held stable while mem_ready=0.
  - On mem_ready=1, the corresponding done output is asserted combinationally in that same cycle. Its rdata output is mem_rdata passed through (for stores the value is don't-care).
  - On that same edge: mem_req goes to 0 and the state returns to IDLE.
  - The non-granted done output is always 0.
- Minimum latency: req seen in IDLE at cycle N, mem_req=1 at N+1, mem_ready at N+1, done at N+1, i.e. 2 cycles. Back-to-back transactions have one IDLE cycle between them.
- Starvation counter (starve_cnt, 4 bits, saturating):
  - Increments on each data grant made while if_req=1.
  - Clears on every fetch grant.
  - Clears on any IDLE cycle with if_req=0.
- Simultaneous d_req and if_req in IDLE: data wins unless starve_cnt==MAX_WAIT, in which case fetch wins.
- mem_ready while in IDLE is ignored.
- Requester dropping req before done: the transaction still completes and done still pulses; the requester must ignore it.
- An X/invalid state recovers to IDLE.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds outputs perf_conflict (32-bit) and perf_wait (32-bit).
  - perf_conflict counts IDLE cycles in which both requests are high.
  - perf_wait counts BUSY cycles with mem_ready=0.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined, the ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - State enum: IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2.
  - Requester ID constants: REQ_IF=0, REQ_D=1.
  - Starvation counter width STARVE_W=4.
- One sub-module, mem_arb_perf, holds the two performance counters and is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0010, mem_ready after 2 wait cycles, mem_rdata=0x0050_0093 -> mem_req high 3 cycles, then if_done=1 with if_rdata=0x0050_0093.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEAD_BEEF, d_wstrb=4'b0011, zero-wait memory -> mem_we=1, mem_wstrb=0011, d_done at cycle 2, if_done stays 0.
- Conflict: if_req and d_req both held high, MAX_WAIT=4, memory zero-wait -> grant order D,D,D,D,I,D,D,D,D,I...
- Reset mid-transaction: reset asserted in cycle 2 of BUSY_D -> no d_done, mem_req=0 after the edge, state=IDLE, next request is served normally.
- mem_ready glitch in IDLE: mem_ready=1 with no requests -> no done pulse, no state change.
- With MEM_ARB_PERF_EN: 3 conflict cycles and 5 wait cycles -> perf_conflict=3, perf_wait=5.
